uio_port_ctrl: RTL and testbench

- Parametrised successor to the tied-off bidirectional IO stage of the tile top level.
- Drives the `uio` data and output-enable lanes from a small register file instead of constants.
- Adds pattern modes: static, binary counter, walking-one, and synchronised loopback.
- Instantiated in the top level between the dedicated-input command decode and the `uio_out`/`uio_oe` pins.

---
 rtl/uio_port_ctrl.sv | 135 +++++++++++++
 tb/tb_uio_port_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_port_ctrl.sv
// Bidirectional IO port controller: register-driven uio_out/uio_oe with static, counter,
// walking-one and synchronised loopback pattern modes, paced by a programmable prescaler.
module uio_port_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic [WIDTH-1:0] uio_in,
    output logic [WIDTH-1:0] uio_out,
    output logic [WIDTH-1:0] uio_oe,
    output logic             tick
);
    localparam int unsigned HiW = DIV_W - WIDTH;

    typedef enum logic [1:0] {ModeStatic, ModeCount, ModeWalk, ModeLoop} mode_e;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] pattern_q;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    mode_e            mode_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    logic             wr_out;
    logic             wr_oe;
    logic             wr_mode;
    logic             wr_div_lo;
    logic             wr_div_hi;
    logic             expiry;
    logic [DIV_W-1:0] div_d;
    logic [WIDTH-1:0] div_hi_rd;
    logic [WIDTH-1:0] rd_mux;
    logic [WIDTH-1:0] pattern_adv;
    mode_e            mode_wr;

    always_comb begin
        wr_out    = wr_en && (wr_addr == 3'd0);
        wr_oe     = wr_en && (wr_addr == 3'd1);
        wr_mode   = wr_en && (wr_addr == 3'd2);
        wr_div_lo = wr_en && (wr_addr == 3'd3);
        wr_div_hi = wr_en && (wr_addr == 3'd4);
        mode_wr   = mode_e'(wr_data[1:0]);
        expiry    = (cnt_q == '0);

        // Reload value must reflect a same-edge DIV write.
        div_d = div_q;
        if (wr_div_lo) div_d[WIDTH-1:0] = wr_data;
        if (wr_div_hi) div_d[DIV_W-1:WIDTH] = wr_data[HiW-1:0];

        div_hi_rd = '0;
        div_hi_rd[HiW-1:0] = div_q[DIV_W-1:WIDTH];

        case (rd_addr)
            3'd0:    rd_mux = out_q;
            3'd1:    rd_mux = oe_q;
            3'd2:    rd_mux = {{(WIDTH-2){1'b0}}, mode_q};
            3'd3:    rd_mux = div_q[WIDTH-1:0];
            3'd4:    rd_mux = div_hi_rd;
            3'd5:    rd_mux = pattern_q;
            3'd6:    rd_mux = sync2_q;
            default: rd_mux = '0;
        endcase

        unique case (mode_q)
            ModeCount: pattern_adv = pattern_q + WIDTH'(1);
            ModeWalk:  pattern_adv = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            default:   pattern_adv = pattern_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            pattern_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            mode_q    <= ModeStatic;
            div_q     <= '0;
            cnt_q     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            uio_out   <= '0;
            uio_oe    <= '0;
            tick      <= 1'b0;
        end else begin
            tick     <= expiry;
            uio_oe   <= oe_q;
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;

            unique case (mode_q)
                ModeStatic: uio_out <= out_q;
                ModeLoop:   uio_out <= sync2_q;
                default:    uio_out <= pattern_q;
            endcase

            sync1_q <= uio_in;
            sync2_q <= sync1_q;

            if (wr_out) out_q <= wr_data;
            if (wr_oe)  oe_q  <= wr_data;
            div_q <= div_d;

            if (expiry || wr_div_lo || wr_div_hi || wr_mode) begin
                cnt_q <= div_d;
            end else begin
                cnt_q <= cnt_q - DIV_W'(1);
            end

            // A mode write reinitialises the pattern and swallows a coincident expiry.
            if (wr_mode) begin
                mode_q <= mode_wr;
                unique case (mode_wr)
                    ModeCount: pattern_q <= '0;
                    ModeWalk:  pattern_q <= WIDTH'(1);
                    default:   pattern_q <= pattern_q;
                endcase
            end else if (expiry) begin
                pattern_q <= pattern_adv;
            end
        end
    end

endmodule

// File: tb/tb_uio_port_ctrl.sv
// Self-checking bench for uio_port_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against an arithmetic reference model.
module tb_uio_port_ctrl;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIV_W = 16;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [2:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [WIDTH-1:0] uio_in;
    logic [WIDTH-1:0] uio_out;
    logic [WIDTH-1:0] uio_oe;
    logic             tick;

    uio_port_ctrl #(
        .WIDTH(WIDTH),
        .DIV_W(DIV_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state as plain integers; m_k counts edges since the last prescaler reload.
    int m_out = 0, m_oe = 0, m_mode = 0, m_div = 0, m_pat = 0, m_s1 = 0, m_s2 = 0, m_k = 0;
    int e_uout = 0, e_uoe = 0, e_rd = 0, e_rdv = 0, e_tick = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int reg_val(input int addr);
        case (addr)
            0:       return m_out;
            1:       return m_oe;
            2:       return m_mode;
            3:       return m_div % 256;
            4:       return m_div / 256;
            5:       return m_pat;
            6:       return m_s2;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit expiry;
        if (rst) begin
            m_out = 0; m_oe = 0; m_mode = 0; m_div = 0; m_pat = 0; m_s1 = 0; m_s2 = 0; m_k = 0;
            e_uout = 0; e_uoe = 0; e_rd = 0; e_rdv = 0; e_tick = 0;
            return;
        end
        m_k++;
        expiry = (m_k % (m_div + 1)) == 0;
        e_tick = int'(expiry);
        e_uoe  = m_oe;
        e_uout = (m_mode == 0) ? m_out : (m_mode == 3) ? m_s2 : m_pat;
        e_rdv  = int'(rd_en);
        if (rd_en) e_rd = reg_val(int'(rd_addr));
        if (expiry && !(wr_en && wr_addr == 3'd2)) begin
            if (m_mode == 1) m_pat = (m_pat + 1) % 256;
            else if (m_mode == 2) m_pat = (m_pat * 2) % 256 + m_pat / 128;
        end
        m_s2 = m_s1;
        m_s1 = int'(uio_in);
        if (wr_en) begin
            case (wr_addr)
                3'd0: m_out = int'(wr_data);
                3'd1: m_oe = int'(wr_data);
                3'd2: begin
                    m_mode = int'(wr_data) % 4;
                    if (m_mode == 1) m_pat = 0;
                    if (m_mode == 2) m_pat = 1;
                    m_k = 0;
                end
                3'd3: begin
                    m_div = (m_div / 256) * 256 + int'(wr_data);
                    m_k = 0;
                end
                3'd4: begin
                    m_div = int'(wr_data) * 256 + m_div % 256;
                    m_k = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("tick", 32'(tick), 32'(e_tick));
        check("uio_out", 32'(uio_out), 32'(e_uout));
        check("uio_oe", 32'(uio_oe), 32'(e_uoe));
        check("rd_valid", 32'(rd_valid), 32'(e_rdv));
        check("rd_data", 32'(rd_data), 32'(e_rd));
    endtask

    task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en = 1'b1; rd_addr = a;
        cyc();
        rd_en = 1'b0;
    endtask

    initial begin
        int ntick;
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        rd_en = 1'b0; rd_addr = 3'd0; uio_in = '0;

        // Reset beats a same-cycle write.
        cyc();
        cyc();
        check("rst_uio_out", 32'(uio_out), 32'h00);
        check("rst_uio_oe", 32'(uio_oe), 32'h00);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        rst = 1'b0; wr_en = 1'b0;
        rd(3'd0);
        check("rst_read_out", 32'(rd_data), 32'h00);
        check("rst_read_valid", 32'(rd_valid), 32'h1);

        // Static mode write/readback.
        wr(3'd1, 8'hF0);
        cyc();
        check("static_oe", 32'(uio_oe), 32'hF0);
        wr(3'd0, 8'hA5);
        cyc();
        check("static_out", 32'(uio_out), 32'hA5);
        rd(3'd0);
        check("read_out", 32'(rd_data), 32'hA5);
        check("read_out_valid", 32'(rd_valid), 32'h1);
        rd(3'd7);
        check("read_reserved", 32'(rd_data), 32'h00);
        wr(3'd5, 8'h55);
        rd(3'd5);
        check("ro_pattern", 32'(rd_data), 32'h00);

        // Counter: DIV=3 gives one tick per 4 cycles; 256 expiries wrap to zero.
        wr(3'd3, 8'd3);
        wr(3'd4, 8'd0);
        wr(3'd2, 8'd1);
        ntick = 0;
        for (int i = 0; i < 1024; i++) begin
            cyc();
            if (tick) ntick++;
        end
        check("count_ticks", 32'(ntick), 32'd256);
        check("count_last_tick", 32'(tick), 32'h1);
        check("count_ff", 32'(uio_out), 32'hFF);
        cyc();
        check("count_wrap", 32'(uio_out), 32'h00);

        // Walking one at DIV=0, then restart by rewriting the same mode.
        wr(3'd3, 8'd0);
        wr(3'd2, 8'd2);
        for (int j = 1; j <= 9; j++) begin
            cyc();
            check("walk_step", 32'(uio_out), 32'(1) << ((j - 1) % 8));
        end
        cyc();
        cyc();
        wr(3'd2, 8'd2);
        cyc();
        check("walk_restart0", 32'(uio_out), 32'h01);
        cyc();
        check("walk_restart1", 32'(uio_out), 32'h02);

        // Loopback: three flops from pin to uio_out.
        wr(3'd2, 8'd3);
        uio_in = 8'h3C;
        cyc();
        check("loop_lat1", 32'(uio_out), 32'h00);
        cyc();
        check("loop_lat2", 32'(uio_out), 32'h00);
        cyc();
        check("loop_lat3", 32'(uio_out), 32'h3C);
        rd(3'd6);
        check("loop_in_sync", 32'(rd_data), 32'h3C);

        // Mode write coincident with expiry: reinit wins, tick still fires.
        wr(3'd3, 8'd3);
        wr(3'd2, 8'd1);
        cyc();
        cyc();
        cyc();
        wr(3'd2, 8'd1);
        check("coll_tick", 32'(tick), 32'h1);
        rd(3'd5);
        check("coll_pattern", 32'(rd_data), 32'h00);

        // Same-cycle read and write of OE returns the old value.
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h0F;
        rd_en = 1'b1; rd_addr = 3'd1;
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rw_same_old", 32'(rd_data), 32'hF0);
        rd(3'd1);
        check("rw_same_new", 32'(rd_data), 32'h0F);

        // Randomized traffic, including occasional reset mid-operation.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 8'($urandom);
            if ((wr_addr == 3'd4) && ($urandom_range(0, 3) != 0)) wr_data = '0;
            if ((wr_addr == 3'd3) && ($urandom_range(0, 1) != 0)) wr_data = 8'($urandom_range(0, 5));
            rd_en   = ($urandom_range(0, 1) == 0);
            rd_addr = 3'($urandom_range(0, 7));
            uio_in  = 8'($urandom);
            cyc();
        end
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
